rf_access_ctrl: RTL and testbench

Initiator-side sequencer for the 16x16 register file. It accepts one register operation at a time over a valid/ready request channel and drives the register file's EN/RW/DA/AA/BA/D ports. It collects the A/B read data one clock later, performs a small ALU operation, writes the result back, and returns the result on a valid/ready response channel. It sits between the instruction decode logic and the register file.

---
 rtl/rf_access_pkg.sv | 26 ++
 rtl/rf_access_alu.sv | 26 ++
 rtl/rf_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_rf_access_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_pkg.sv
// Shared opcodes, FSM state encoding and register-file RW encodings for the
// register-file access sequencer.
package rf_access_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_RD  = 3'b111;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_WR   = 2'b01;
   localparam logic [1:0] RW_RD   = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StExec,
      StWrite,
      StResp
   } state_e;

endpackage

// File: rtl/rf_access_alu.sv
// Combinational ALU for the register-file sequencer; RD passes operand A through.
module rf_access_alu
   import rf_access_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o
);

   always_comb begin
      result_o = '0;
      case (op_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_RD:   result_o = a_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/rf_access_ctrl.sv
// Serialised request/response sequencer driving a register file: read, ALU,
// write-back, then hold the result on the response channel.
module rf_access_ctrl
   import rf_access_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_op_i,
   input  logic [ADDR_W-1:0] req_rd_i,
   input  logic [ADDR_W-1:0] req_rs_i,
   input  logic [ADDR_W-1:0] req_rt_i,
   input  logic [DATA_W-1:0] req_imm_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_zero_o,
   output logic              rf_en_o,
   output logic [1:0]        rf_rw_o,
   output logic [ADDR_W-1:0] rf_da_o,
   output logic [ADDR_W-1:0] rf_aa_o,
   output logic [ADDR_W-1:0] rf_ba_o,
   output logic [DATA_W-1:0] rf_d_o,
   input  logic [DATA_W-1:0] rf_a_i,
   input  logic [DATA_W-1:0] rf_b_i
);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [ADDR_W-1:0] rs_q, rs_d;
   logic [ADDR_W-1:0] rt_q, rt_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] alu_result;
   logic              accept;

   rf_access_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i     (op_q),
      .a_i      (rf_a_i),
      .b_i      (rf_b_i),
      .result_o (alu_result)
   );

   assign accept = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         op_q     <= OP_NOP;
         rd_q     <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         result_q <= result_d;
      end
   end

   // The LDI immediate is captured straight into result_q, which feeds rf_d in WRITE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d = req_op_i;
               rd_d = req_rd_i;
               rs_d = req_rs_i;
               rt_d = req_rt_i;
               if (req_op_i == OP_NOP) begin
                  result_d = '0;
                  state_d  = StResp;
               end else if (req_op_i == OP_LDI) begin
                  result_d = req_imm_i;
                  state_d  = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead:  state_d = StExec;
         StExec: begin
            result_d = alu_result;
            state_d  = (op_q == OP_RD) ? StResp : StWrite;
         end
         StWrite: state_d = StResp;
         StResp:  if (rsp_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // All outputs are forced inactive while reset is high so an aborted write never lands.
   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_data_o  = '0;
      rsp_zero_o  = 1'b0;
      rf_en_o     = 1'b0;
      rf_rw_o     = RW_NONE;
      rf_da_o     = '0;
      rf_aa_o     = '0;
      rf_ba_o     = '0;
      rf_d_o      = '0;
      if (!reset_i) begin
         unique case (state_q)
            StIdle: req_ready_o = 1'b1;
            StRead: begin
               rf_en_o = 1'b1;
               rf_rw_o = RW_RD;
               rf_aa_o = rs_q;
               rf_ba_o = rt_q;
            end
            StWrite: begin
               rf_en_o = 1'b1;
               rf_rw_o = RW_WR;
               rf_da_o = rd_q;
               rf_d_o  = result_q;
            end
            StResp: begin
               rsp_valid_o = 1'b1;
               rsp_data_o  = result_q;
               rsp_zero_o  = (result_q == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed self-checking bench for rf_access_ctrl with a behavioural 16x16 register file.
module tb_rf_access_ctrl;
   import rf_access_pkg::*;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [2:0]    req_op = OP_NOP;
   logic [AW-1:0] req_rd = '0;
   logic [AW-1:0] req_rs = '0;
   logic [AW-1:0] req_rt = '0;
   logic [DW-1:0] req_imm = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_zero;
   logic          rf_en;
   logic [1:0]    rf_rw;
   logic [AW-1:0] rf_da, rf_aa, rf_ba;
   logic [DW-1:0] rf_d;
   logic [DW-1:0] rf_a = '0;
   logic [DW-1:0] rf_b = '0;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] mem [16] = '{default: '0};
   int            en_cnt = 0;
   int            wr_cnt = 0;
   int            bad_rw = 0;
   logic [AW-1:0] last_da = '0;
   logic [DW-1:0] last_d = '0;
   logic [1:0]    rw_tr [1:10];

   logic [DW-1:0] data;
   logic          zero;
   int            lat;
   int            c0;

   rf_access_ctrl #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_rd_i    (req_rd),
      .req_rs_i    (req_rs),
      .req_rt_i    (req_rt),
      .req_imm_i   (req_imm),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_zero_o  (rsp_zero),
      .rf_en_o     (rf_en),
      .rf_rw_o     (rf_rw),
      .rf_da_o     (rf_da),
      .rf_aa_o     (rf_aa),
      .rf_ba_o     (rf_ba),
      .rf_d_o      (rf_d),
      .rf_a_i      (rf_a),
      .rf_b_i      (rf_b)
   );

   always #5 clk = ~clk;

   // Register file: read data appears the edge after a read cycle.
   always @(posedge clk) begin
      if (rf_en) begin
         en_cnt <= en_cnt + 1;
         if (rf_rw == 2'b11) bad_rw <= bad_rw + 1;
         if (rf_rw == RW_RD) begin
            rf_a <= mem[rf_aa];
            rf_b <= mem[rf_ba];
         end
         if (rf_rw == RW_WR) begin
            mem[rf_da] <= rf_d;
            wr_cnt     <= wr_cnt + 1;
            last_da    <= rf_da;
            last_d     <= rf_d;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_op(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic [DW-1:0] imm, input int hold,
                        output logic [DW-1:0] d, output logic z, output int l);
      chk("req_ready_idle", {31'b0, req_ready}, 1);
      req_valid = 1'b1;
      req_op    = op;
      req_rd    = rd;
      req_rs    = rs;
      req_rt    = rt;
      req_imm   = imm;
      if (hold > 0) rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      l = 1;
      rw_tr[1] = rf_rw;
      while (!rsp_valid && l < 10) begin
         @(negedge clk);
         l++;
         rw_tr[l] = rf_rw;
      end
      chk("rsp_valid_seen", {31'b0, rsp_valid}, 1);
      d = rsp_data;
      z = rsp_zero;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, rsp_valid}, 1);
         chk("hold_data", {16'b0, rsp_data}, {16'b0, d});
         chk("hold_zero", {31'b0, rsp_zero}, {31'b0, z});
         chk("hold_req_ready", {31'b0, req_ready}, 0);
         chk("hold_rf_en", {31'b0, rf_en}, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_done", {31'b0, rsp_valid}, 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_data", {16'b0, rsp_data}, 0);
      chk("rst_rsp_zero", {31'b0, rsp_zero}, 0);
      chk("rst_rf_en", {31'b0, rf_en}, 0);
      chk("rst_rf_rw", {30'b0, rf_rw}, 0);
      chk("rst_rf_addr", {20'b0, rf_da, rf_aa, rf_ba}, 0);
      chk("rst_rf_d", {16'b0, rf_d}, 0);
      reset = 1'b0;
      #1;

      // 1: LDI, LDI, ADD
      do_op(OP_LDI, 4'd3, 4'd0, 4'd0, 16'h1234, 0, data, zero, lat);
      chk("ldi_lat", lat, 2);
      chk("ldi_data", {16'b0, data}, 32'h1234);
      do_op(OP_LDI, 4'd5, 4'd0, 4'd0, 16'h0011, 0, data, zero, lat);
      do_op(OP_ADD, 4'd7, 4'd3, 4'd5, 16'h0, 0, data, zero, lat);
      chk("add_data", {16'b0, data}, 32'h1245);
      chk("add_zero", {31'b0, zero}, 0);
      chk("add_wr_da", {28'b0, last_da}, 7);
      chk("add_wr_d", {16'b0, last_d}, 32'h1245);

      // 3: timing of the ADD just issued
      chk("add_lat", lat, 4);
      chk("add_rw_t1", {30'b0, rw_tr[1]}, {30'b0, RW_RD});
      chk("add_rw_t2", {30'b0, rw_tr[2]}, {30'b0, RW_NONE});
      chk("add_rw_t3", {30'b0, rw_tr[3]}, {30'b0, RW_WR});

      // 2: wrap-around and zero flag
      do_op(OP_LDI, 4'd1, 4'd0, 4'd0, 16'h0000, 0, data, zero, lat);
      do_op(OP_LDI, 4'd2, 4'd0, 4'd0, 16'h0001, 0, data, zero, lat);
      do_op(OP_SUB, 4'd4, 4'd1, 4'd2, 16'h0, 0, data, zero, lat);
      chk("sub_data", {16'b0, data}, 32'hFFFF);
      chk("sub_zero", {31'b0, zero}, 0);
      do_op(OP_LDI, 4'd6, 4'd0, 4'd0, 16'hFFFF, 0, data, zero, lat);
      do_op(OP_ADD, 4'd8, 4'd6, 4'd2, 16'h0, 0, data, zero, lat);
      chk("addwrap_data", {16'b0, data}, 0);
      chk("addwrap_zero", {31'b0, zero}, 1);
      chk("addwrap_mem", {16'b0, mem[8]}, 0);

      // 3 (cont.): LDI immediately followed by RD
      do_op(OP_LDI, 4'd2, 4'd0, 4'd0, 16'hAAAA, 0, data, zero, lat);
      c0 = wr_cnt;
      do_op(OP_RD, 4'd0, 4'd2, 4'd0, 16'h0, 0, data, zero, lat);
      chk("rd_data", {16'b0, data}, 32'hAAAA);
      chk("rd_lat", lat, 3);
      chk("rd_no_write", wr_cnt, c0);

      // 4: XOR with back-pressure, plus AND/OR
      do_op(OP_LDI, 4'd9, 4'd0, 4'd0, 16'h0FF0, 0, data, zero, lat);
      do_op(OP_LDI, 4'd10, 4'd0, 4'd0, 16'h00FF, 0, data, zero, lat);
      do_op(OP_XOR, 4'd11, 4'd9, 4'd10, 16'h0, 5, data, zero, lat);
      chk("xor_data", {16'b0, data}, 32'h0F0F);
      chk("xor_mem", {16'b0, mem[11]}, 32'h0F0F);
      do_op(OP_AND, 4'd13, 4'd9, 4'd10, 16'h0, 0, data, zero, lat);
      chk("and_data", {16'b0, data}, 32'h00F0);
      do_op(OP_OR, 4'd14, 4'd9, 4'd10, 16'h0, 0, data, zero, lat);
      chk("or_data", {16'b0, data}, 32'h0FFF);

      // 5: reset during WRITE aborts the write
      do_op(OP_LDI, 4'd12, 4'd0, 4'd0, 16'h5555, 0, data, zero, lat);
      c0 = wr_cnt;
      req_valid = 1'b1;
      req_op    = OP_ADD;
      req_rd    = 4'd12;
      req_rs    = 4'd3;
      req_rt    = 4'd5;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_write", {30'b0, rf_rw}, {30'b0, RW_WR});
      reset = 1'b1;
      #1;
      chk("abort_rf_en", {31'b0, rf_en}, 0);
      chk("abort_rsp_valid", {31'b0, rsp_valid}, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_req_ready", {31'b0, req_ready}, 1);
      chk("abort_no_write", wr_cnt, c0);
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, rsp_valid}, 0);
      do_op(OP_RD, 4'd0, 4'd12, 4'd0, 16'h0, 0, data, zero, lat);
      chk("abort_rd_r12", {16'b0, data}, 32'h5555);

      // 6: NOP
      c0 = en_cnt;
      do_op(OP_NOP, 4'd1, 4'd2, 4'd3, 16'h1111, 0, data, zero, lat);
      chk("nop_lat", lat, 1);
      chk("nop_data", {16'b0, data}, 0);
      chk("nop_zero", {31'b0, zero}, 1);
      chk("nop_no_rf_en", en_cnt, c0);

      chk("never_rw11", bad_rw, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
